// File: rtl/spectrum_band_scheduler_if.sv
// -----------------------------------------------------------------------------
// spectrum_band_scheduler_if
// Read port of the FFT magnitude RAM (registered read: q is valid the cycle
// after the address is presented).
//   ram_rd_en    read strobe            (master -> slave)
//   ram_rd_addr  read address, ADDR_W   (master -> slave)
//   ram_rd_data  RAM q, DATA_W          (slave  -> master)
// master = the band scheduler, slave = the RAM.
// -----------------------------------------------------------------------------
interface spectrum_band_scheduler_if #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 8
);
  logic              ram_rd_en;
  logic [ADDR_W-1:0] ram_rd_addr;
  logic [DATA_W-1:0] ram_rd_data;

  modport master (output ram_rd_en, output ram_rd_addr, input ram_rd_data);
  modport slave  (input ram_rd_en, input ram_rd_addr, output ram_rd_data);
endinterface

// File: rtl/spectrum_band_scheduler.sv
// -----------------------------------------------------------------------------
// spectrum_band_scheduler
// Per frame, reads FFT magnitude bins 1..511, reduces them to the peak of 18
// log-spaced bands and applies instant-attack / linear-decay smoothing to the
// 18 LED duty values.
//   clk         system clock
//   rst_n       asynchronous reset, ACTIVE-HIGH despite its name
//   frame_done  pulse from the FFT writer: a full spectrum is in RAM
//   filter_sel  1 = all bands, 0 = low-pass (bands 9..17 forced to 0),
//               sampled once per frame
//   rd          RAM read port (master side)
//   duty_out    band b on bits [8b+7:8b]
//   busy        high from the first SCAN cycle through the DONE cycle
//   frame_ack   one-cycle pulse once all duties of the frame are committed
//   overrun     one-cycle pulse the cycle after a frame_done seen while busy
// -----------------------------------------------------------------------------
module spectrum_band_scheduler #(
  parameter int NUM_BANDS  = 18,
  parameter int ADDR_W     = 10,
  parameter int DATA_W     = 8,
  parameter int DECAY_STEP = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          frame_done,
  input  logic                          filter_sel,
  spectrum_band_scheduler_if.master     rd,
  output logic [NUM_BANDS*DATA_W-1:0]   duty_out,
  output logic                          busy,
  output logic                          frame_ack,
  output logic                          overrun
);

  localparam int BAND_W        = $clog2(NUM_BANDS);
  localparam int LP_FIRST_BAND = 9;
  localparam logic [ADDR_W-1:0] LAST_SCAN_BIN = ADDR_W'(511);

  typedef enum logic [1:0] {IDLE, SCAN, DRAIN, DONE} state_t;

  state_t              state;
  logic                filter_q;    // filter_sel frozen for the whole frame

  // Read-data pipeline: data arriving this cycle belongs to data_bin.
  logic                data_vld;
  logic [ADDR_W-1:0]   data_bin;

  logic [BAND_W-1:0]   band_idx;
  logic                first_q;     // next valid bin is the first of band_idx
  logic [DATA_W-1:0]   peak_q;
  logic [DATA_W-1:0]   duty [NUM_BANDS];

  logic [DATA_W-1:0]   peak_in;
  logic [DATA_W-1:0]   band_p;
  logic [DATA_W-1:0]   cur_duty;
  logic [DATA_W-1:0]   decayed;
  logic [DATA_W-1:0]   new_duty;
  logic                is_last;

  // Inclusive upper bin of each band.
  function automatic logic [ADDR_W-1:0] last_bin(input logic [BAND_W-1:0] b);
    case (b)
      BAND_W'(0):  last_bin = ADDR_W'(1);
      BAND_W'(1):  last_bin = ADDR_W'(2);
      BAND_W'(2):  last_bin = ADDR_W'(3);
      BAND_W'(3):  last_bin = ADDR_W'(5);
      BAND_W'(4):  last_bin = ADDR_W'(7);
      BAND_W'(5):  last_bin = ADDR_W'(11);
      BAND_W'(6):  last_bin = ADDR_W'(15);
      BAND_W'(7):  last_bin = ADDR_W'(23);
      BAND_W'(8):  last_bin = ADDR_W'(31);
      BAND_W'(9):  last_bin = ADDR_W'(47);
      BAND_W'(10): last_bin = ADDR_W'(63);
      BAND_W'(11): last_bin = ADDR_W'(95);
      BAND_W'(12): last_bin = ADDR_W'(127);
      BAND_W'(13): last_bin = ADDR_W'(191);
      BAND_W'(14): last_bin = ADDR_W'(255);
      BAND_W'(15): last_bin = ADDR_W'(383);
      BAND_W'(16): last_bin = ADDR_W'(447);
      default:     last_bin = ADDR_W'(511);
    endcase
  endfunction

  // ---------------------------------------------------------------------------
  // Sequencer: IDLE -> SCAN (bins 1..511) -> DRAIN -> DONE -> IDLE
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state          <= IDLE;
      filter_q       <= 1'b0;
      rd.ram_rd_en   <= 1'b0;
      rd.ram_rd_addr <= '0;
      busy           <= 1'b0;
      frame_ack      <= 1'b0;
      overrun        <= 1'b0;
    end else begin
      // NOTE: non-blocking default followed by a conditional override in the
      // case below; the last <= in program order wins at the clock edge.
      frame_ack <= 1'b0;
      overrun   <= frame_done && (state != IDLE);
      case (state)
        IDLE: begin
          if (frame_done) begin
            state          <= SCAN;
            filter_q       <= filter_sel;
            rd.ram_rd_en   <= 1'b1;
            rd.ram_rd_addr <= ADDR_W'(1);
            busy           <= 1'b1;
          end
        end
        SCAN: begin
          if (rd.ram_rd_addr == LAST_SCAN_BIN) begin
            state          <= DRAIN;
            rd.ram_rd_en   <= 1'b0;
            rd.ram_rd_addr <= '0;
          end else begin
            rd.ram_rd_addr <= rd.ram_rd_addr + ADDR_W'(1);
          end
        end
        DRAIN: begin
          state     <= DONE;
          frame_ack <= 1'b1;
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Band peak and smoothing
  // ---------------------------------------------------------------------------
  // NOTE: every always_comb output gets a value on every path so no latch
  // is inferred.
  always_comb begin
    peak_in  = first_q ? rd.ram_rd_data
                       : ((rd.ram_rd_data > peak_q) ? rd.ram_rd_data : peak_q);
    band_p   = (!filter_q && (band_idx >= BAND_W'(LP_FIRST_BAND))) ? '0 : peak_in;
    cur_duty = duty[band_idx];
    decayed  = (cur_duty >= DATA_W'(DECAY_STEP)) ? cur_duty - DATA_W'(DECAY_STEP) : '0;
    if (band_p >= cur_duty) new_duty = band_p;
    else                    new_duty = (decayed > band_p) ? decayed : band_p;
    is_last  = data_vld && (data_bin == last_bin(band_idx));
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      data_vld <= 1'b0;
      data_bin <= '0;
      band_idx <= '0;
      first_q  <= 1'b1;
      peak_q   <= '0;
      // NOTE: the duty bank is a small register file, not RAM, so it is reset
      // explicitly; an aborted frame therefore leaves no partial duties.
      for (int b = 0; b < NUM_BANDS; b++) duty[b] <= '0;
    end else begin
      data_vld <= rd.ram_rd_en;
      data_bin <= rd.ram_rd_addr;
      if (data_vld) begin
        if (is_last) begin
          duty[band_idx] <= new_duty;
          band_idx       <= (band_idx == BAND_W'(NUM_BANDS - 1)) ? '0
                                                                 : band_idx + BAND_W'(1);
          first_q        <= 1'b1;
        end else begin
          peak_q  <= peak_in;
          first_q <= 1'b0;
        end
      end
    end
  end

  for (genvar g = 0; g < NUM_BANDS; g++) begin : g_duty
    assign duty_out[g*DATA_W +: DATA_W] = duty[g];
  end

endmodule

// File: tb/tb_spectrum_band_scheduler.sv
// -----------------------------------------------------------------------------
// tb_spectrum_band_scheduler
// Scoreboard bench: stimulus pushes expected scan starts, frame_ack events
// (cycle + duty vector) and overrun cycles; a negedge monitor pops and
// compares whenever the DUT presents them. Expected duties are hand-computed.
// -----------------------------------------------------------------------------
module tb_spectrum_band_scheduler;
  localparam int NB = 18;
  localparam int DW = NB * 8;

  typedef int vec_t [NB];
  typedef struct { int cyc; logic [DW-1:0] duty; } ack_t;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic frame_done = 1'b0;
  logic filter_sel = 1'b1;
  logic [DW-1:0] duty_out;
  logic busy, frame_ack, overrun;

  spectrum_band_scheduler_if rd_bus ();

  spectrum_band_scheduler dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .frame_done (frame_done),
    .filter_sel (filter_sel),
    .rd         (rd_bus),
    .duty_out   (duty_out),
    .busy       (busy),
    .frame_ack  (frame_ack),
    .overrun    (overrun)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // RAM model with registered read port.
  logic [7:0] mem [1024];
  always @(posedge clk) if (rd_bus.ram_rd_en) rd_bus.ram_rd_data <= mem[rd_bus.ram_rd_addr];

  int n_checks = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_unexpected(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: event at cycle %0d, expected none", name, cyc);
  endtask

  function automatic logic [DW-1:0] pack(input vec_t v);
    logic [DW-1:0] r;
    for (int b = 0; b < NB; b++) r[b*8 +: 8] = 8'(v[b]);
    return r;
  endfunction

  // Scoreboard queues
  int   exp_start [$];
  ack_t exp_ack [$];
  int   exp_ov [$];

  // Monitor
  int en_cycles = 0;
  initial begin
    logic prev_en;
    int   burst_cnt;
    int   addr_err;
    ack_t a;
    prev_en = 1'b0;
    burst_cnt = 0;
    addr_err = 0;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        prev_en = 1'b0;
        burst_cnt = 0;
        addr_err = 0;
      end else begin
        if (rd_bus.ram_rd_en) begin
          en_cycles++;
          if (!prev_en) begin
            burst_cnt = 0;
            addr_err = 0;
            if (exp_start.size() == 0) fail_unexpected("scan_start");
            else check("scan_start_cycle", DW'(cyc), DW'(exp_start.pop_front()));
          end
          burst_cnt++;
          if (int'(rd_bus.ram_rd_addr) != burst_cnt) addr_err++;
        end else if (prev_en) begin
          check("scan_length", DW'(burst_cnt), DW'(511));
          check("scan_addr_errors", DW'(addr_err), DW'(0));
        end
        prev_en = rd_bus.ram_rd_en;

        if (frame_ack) begin
          if (exp_ack.size() == 0) fail_unexpected("frame_ack");
          else begin
            a = exp_ack.pop_front();
            check("frame_ack_cycle", DW'(cyc), DW'(a.cyc));
            check("duty_at_ack", duty_out, a.duty);
          end
        end

        if (overrun) begin
          if (exp_ov.size() == 0) fail_unexpected("overrun");
          else check("overrun_cycle", DW'(cyc), DW'(exp_ov.pop_front()));
        end
      end
    end
  end

  // Stimulus helpers (called at posedge + #1)
  task automatic wait_cyc(input int t);
    while (cyc < t) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse_at(input int t);
    wait_cyc(t);
    frame_done = 1'b1;
    @(posedge clk);
    #1;
    frame_done = 1'b0;
  endtask

  task automatic frame_at(input int t, input vec_t e);
    ack_t a;
    a.cyc  = t + 513;
    a.duty = pack(e);
    exp_start.push_back(t + 1);
    exp_ack.push_back(a);
    pulse_at(t);
  endtask

  task automatic load_ramp();
    for (int k = 0; k < 1024; k++) mem[k] = 8'(k);
  endtask

  task automatic load_zero();
    for (int k = 0; k < 1024; k++) mem[k] = 8'h00;
  endtask

  vec_t ramp_v, decay_v, attack_v, lp_v;
  int t;

  initial begin
    ramp_v   = '{1, 2, 3, 5, 7, 11, 15, 23, 31, 47, 63, 95, 127, 191, 255, 127, 191, 255};
    decay_v  = '{0, 0, 0, 1, 3, 7, 11, 19, 27, 43, 59, 91, 123, 187, 251, 123, 187, 251};
    attack_v = '{0, 0, 0, 1, 3, 7, 11, 19, 27, 43, 59, 91, 123, 187, 251, 200, 187, 251};
    lp_v     = '{1, 2, 3, 5, 7, 11, 15, 23, 31, 0, 0, 0, 0, 0, 0, 0, 0, 0};

    load_ramp();
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b0;

    // Reset asserted mid-idle
    repeat (5) @(posedge clk);
    #1 rst_n = 1'b1;
    #1;
    check("rst_duty_out", duty_out, '0);
    check("rst_busy", DW'(busy), DW'(0));
    check("rst_frame_ack", DW'(frame_ack), DW'(0));
    check("rst_overrun", DW'(overrun), DW'(0));
    check("rst_rd_en", DW'(rd_bus.ram_rd_en), DW'(0));
    check("rst_rd_addr", DW'(rd_bus.ram_rd_addr), DW'(0));
    @(posedge clk);
    #1 rst_n = 1'b0;

    // No frame_done: no reads for 2000 cycles
    t = cyc;
    wait_cyc(t + 2000);
    check("idle_no_reads", DW'(en_cycles), DW'(0));

    // Ramp frame
    t = cyc + 2;
    wait_cyc(t);
    check("busy_before_frame", DW'(busy), DW'(0));
    frame_at(t, ramp_v);
    check("busy_first_scan", DW'(busy), DW'(1));
    wait_cyc(t + 513);
    check("busy_done_cycle", DW'(busy), DW'(1));
    wait_cyc(t + 514);
    check("busy_after_done", DW'(busy), DW'(0));
    wait_cyc(t + 520);

    // Decay frame: all-zero spectrum
    load_zero();
    t = cyc + 3;
    frame_at(t, decay_v);
    wait_cyc(t + 520);

    // Ramp again, then attack over decay in band 15
    load_ramp();
    t = cyc + 3;
    frame_at(t, ramp_v);
    wait_cyc(t + 520);
    load_zero();
    mem[300] = 8'd200;
    t = cyc + 3;
    frame_at(t, attack_v);
    wait_cyc(t + 520);

    // Low-pass from reset; filter_sel change mid-frame must not apply
    rst_n = 1'b1;
    @(posedge clk);
    #1 rst_n = 1'b0;
    load_ramp();
    filter_sel = 1'b0;
    t = cyc + 3;
    frame_at(t, lp_v);
    wait_cyc(t + 50);
    filter_sel = 1'b1;
    wait_cyc(t + 520);

    // Overrun: frame_done at T, T+100 and T+513 (filter now full band)
    t = cyc + 3;
    frame_at(t, ramp_v);
    exp_ov.push_back(t + 101);
    pulse_at(t + 100);
    exp_ov.push_back(t + 514);
    pulse_at(t + 513);
    wait_cyc(t + 700);

    // Reset in the middle of a scan
    t = cyc + 3;
    frame_at(t, ramp_v);
    wait_cyc(t + 200);
    rst_n = 1'b1;
    exp_start.delete();
    exp_ack.delete();
    #1;
    check("midscan_rst_duty", duty_out, '0);
    check("midscan_rst_busy", DW'(busy), DW'(0));
    check("midscan_rst_rd_en", DW'(rd_bus.ram_rd_en), DW'(0));
    @(posedge clk);
    #1 rst_n = 1'b0;

    // A later frame runs normally
    t = cyc + 3;
    frame_at(t, ramp_v);
    wait_cyc(t + 520);

    check("pending_scan_starts", DW'(exp_start.size()), DW'(0));
    check("pending_frame_acks", DW'(exp_ack.size()), DW'(0));
    check("pending_overruns", DW'(exp_ov.size()), DW'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
